audio_level_meter: RTL and testbench
====================================

Name: audio_level_meter

Overview:
- Downstream consumer of the dual-clock audio sample FIFO, on its read side in the 50 MHz domain.
- Pops 32-bit stereo sample words and computes per-channel windowed peak magnitude with linear decay.
- Presents per-channel bar heights, frame-synchronised, to the VGA drawing logic for the visualizer.

Parameters:
- WINDOW, 1024, samples per peak-measurement window (power of two, >=2).
- DECAY, 64, magnitude units subtracted from the held level per window.
- BAR_BITS, 9, width of bar-height outputs.
- BAR_MAX, 479, clamp value for bar heights (pixels).

Ports:
- clk  in  1  system clock (50 MHz, same as FIFO rdclk).
- reset_n  in  1  asynchronous active-low reset.
- fifo_q  in  32  FIFO read data: [31:16] left, [15:0] right, signed two's complement.
- fifo_rdempty  in  1  FIFO empty flag (rdclk domain).
- fifo_rdreq  out  1  FIFO read request, registered.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- level_l  out  BAR_BITS  left bar height.
- level_r  out  BAR_BITS  right bar height.
- window_done  out  1  one-cycle pulse on each window commit.

Behaviour:
- Reset: asynchronous, active-low. FSM=IDLE. fifo_rdreq=0, level_l=0, level_r=0, window_done=0. Window peaks, held levels and sample count all 0.
- FIFO is normal (non-show-ahead) mode: fifo_q is valid in the cycle after the cycle where fifo_rdreq is high.
- FSM states: IDLE, REQ, WAIT, PROC.
  - IDLE: if fifo_rdempty==0, go to REQ; else stay.
  - REQ: fifo_rdreq=1 for exactly this cycle; go to WAIT.
  - WAIT: latch fifo_q into the sample register; go to PROC.
  - PROC: update peaks and count; go to IDLE.
- fifo_rdreq is high only in REQ. Never asserted while fifo_rdempty=1 is sampled in IDLE.
- Continuous non-empty throughput: one pop every 4 cycles.
- Magnitude per channel: mag = |s|, 15 bits. -32768 saturates to 32767.
- PROC (per channel): win_peak <= max(win_peak, mag). count increments, wrapping at WINDOW.
- Window commit, in PROC when count==WINDOW-1:
  - held <= max(win_peak_incl_current, sat0(held - DECAY)), where sat0 clamps at 0.
  - win_peak <= 0; count <= 0.
  - window_done=1 for the next cycle only.
- Scaling: bar = min(held[14:6], BAR_MAX), using the top BAR_BITS of a 15-bit magnitude.
- frame_tick high: level_l/level_r <= scaled held values on the next edge. Outputs change only on frame_tick.
- frame_tick in the same cycle as a commit: outputs take the pre-commit held value. The new value appears at the next frame_tick.
- frame_tick pulses with no commits in between: outputs are re-latched with unchanged values.
- Reset mid-read (in REQ/WAIT/PROC): the popped word is discarded, no partial update; FSM returns to IDLE.
- fifo_rdempty asserting during WAIT/PROC has no effect on the current sample. It is re-evaluated in IDLE.
- DECAY > held: held becomes win_peak, which may be 0.

Decomposition:
- Package audio_vis_pkg:
  - SAMPLE_W=16, MAG_W=15.
  - Enum meter_state_t {IDLE, REQ, WAIT, PROC}.
  - Function abs_sat(signed [15:0]) returning [14:0].
- Sub-module peak_decay_channel, instantiated twice (L/R):
  - Inputs: sample, sample_valid (PROC), commit, frame_tick.
  - Outputs: bar.
  - Holds win_peak, held, and output register.
- Top holds the FSM, count, rdreq and window_done.

Test Plan:
- Reset asserted mid-stream -> fifo_rdreq=0, level_l=level_r=0, window_done=0 immediately; FSM IDLE after release.
- fifo_rdempty=1 held for 100 cycles -> fifo_rdreq never asserted. Then non-empty for 3 words -> exactly 3 one-cycle rdreq pulses, 4 cycles apart.
- WINDOW=4; push 4 words 32'h4000_C000 (L=16384, R=-16384) -> window_done after the 4th PROC; next frame_tick gives level_l=256, level_r=256.
- WINDOW=4; word 32'h8000_7FFF -> mag 32767 both channels -> after commit + frame_tick, level_l=level_r=479 (clamped from 511).
- WINDOW=4, DECAY=64; window of 16384 then a window of zeros -> held=16320 -> level_l=255 after the second commit + frame_tick. DECAY=20000 -> level_l=0.
- frame_tick coincident with the commit cycle of the first 16384 window -> outputs stay 0; next frame_tick gives 256.

Source files
------------

// File: rtl/audio_vis_pkg.sv
// Shared types and helpers for the audio level meter.
package audio_vis_pkg;

  localparam int SAMPLE_W = 16;
  localparam int MAG_W    = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    PROC = 2'd3
  } meter_state_t;

  // Magnitude of a signed sample; -32768 has no 15-bit magnitude so it saturates.
  function automatic logic [MAG_W-1:0] abs_sat(input logic signed [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] neg;
    neg = '0;
    if (!s[SAMPLE_W-1]) begin
      return s[MAG_W-1:0];
    end
    neg = -s;
    if (neg[SAMPLE_W-1]) begin
      return '1;
    end
    return neg[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/peak_decay_channel.sv
// One audio channel: windowed peak capture, linear decay of the held level,
// and a frame-synchronised bar height register.
module peak_decay_channel
  import audio_vis_pkg::*;
#(
  parameter int DECAY    = 64,
  parameter int BAR_BITS = 9,
  parameter int BAR_MAX  = 479
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic                       sample_valid_i,
  input  logic                       commit_i,
  input  logic                       frame_tick_i,
  output logic [BAR_BITS-1:0]        bar_o
);

  // A decay larger than any magnitude simply empties the held level.
  localparam int                  DECAY_SAT = (DECAY > 32767) ? 32767 : DECAY;
  localparam logic [MAG_W-1:0]    DECAY_C   = MAG_W'(DECAY_SAT);
  localparam logic [BAR_BITS-1:0] BAR_MAX_C = BAR_BITS'(BAR_MAX);

  logic [MAG_W-1:0]    mag;
  logic [MAG_W-1:0]    peak_inc;
  logic [MAG_W-1:0]    decayed;
  logic [MAG_W-1:0]    held_d;
  logic [MAG_W-1:0]    win_peak_q;
  logic [MAG_W-1:0]    held_q;
  logic [BAR_BITS-1:0] bar_raw;
  logic [BAR_BITS-1:0] bar_d;
  logic [BAR_BITS-1:0] bar_q;

  // Peak including the current sample, decayed held level and the clamped bar.
  always_comb begin
    mag      = abs_sat(sample_i);
    peak_inc = (mag > win_peak_q) ? mag : win_peak_q;
    decayed  = (held_q > DECAY_C) ? (held_q - DECAY_C) : '0;
    held_d   = (peak_inc > decayed) ? peak_inc : decayed;
    bar_raw  = held_q[MAG_W-1 -: BAR_BITS];
    bar_d    = (bar_raw > BAR_MAX_C) ? BAR_MAX_C : bar_raw;
  end

  // Bar samples the held level before any same-cycle commit lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_peak_q <= '0;
      held_q     <= '0;
      bar_q      <= '0;
    end else begin
      if (sample_valid_i) begin
        if (commit_i) begin
          held_q     <= held_d;
          win_peak_q <= '0;
        end else begin
          win_peak_q <= peak_inc;
        end
      end
      if (frame_tick_i) begin
        bar_q <= bar_d;
      end
    end
  end

  assign bar_o = bar_q;

endmodule

// File: rtl/audio_level_meter.sv
// Stereo level meter fed from the read side of the audio sample FIFO.
// Pops one word per four cycles, tracks window peaks and presents bar heights
// latched on frame_tick.
module audio_level_meter
  import audio_vis_pkg::*;
#(
  parameter int WINDOW   = 1024,
  parameter int DECAY    = 64,
  parameter int BAR_BITS = 9,
  parameter int BAR_MAX  = 479
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [31:0]         fifo_q,
  input  logic                fifo_rdempty,
  output logic                fifo_rdreq,
  input  logic                frame_tick,
  output logic [BAR_BITS-1:0] level_l,
  output logic [BAR_BITS-1:0] level_r,
  output logic                window_done
);

  localparam int               CNT_W    = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  meter_state_t     state_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      sample_q;
  logic             rdreq_q;
  logic             window_done_q;
  logic             proc;
  logic             commit;

  assign proc   = (state_q == PROC);
  assign commit = proc && (count_q == CNT_LAST);

  // Read sequencer: FIFO data arrives the cycle after the request (non-show-ahead).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      sample_q      <= '0;
      rdreq_q       <= 1'b0;
      window_done_q <= 1'b0;
    end else begin
      rdreq_q       <= 1'b0;
      window_done_q <= commit;
      case (state_q)
        IDLE: begin
          if (!fifo_rdempty) begin
            state_q <= REQ;
            rdreq_q <= 1'b1;
          end
        end
        REQ:  state_q <= WAIT;
        WAIT: begin
          sample_q <= fifo_q;
          state_q  <= PROC;
        end
        PROC: begin
          count_q <= commit ? '0 : count_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rdreq  = rdreq_q;
  assign window_done = window_done_q;

  peak_decay_channel #(
    .DECAY    (DECAY),
    .BAR_BITS (BAR_BITS),
    .BAR_MAX  (BAR_MAX)
  ) u_chan_l (
    .clk            (clk),
    .reset_n        (reset_n),
    .sample_i       (sample_q[31:16]),
    .sample_valid_i (proc),
    .commit_i       (commit),
    .frame_tick_i   (frame_tick),
    .bar_o          (level_l)
  );

  peak_decay_channel #(
    .DECAY    (DECAY),
    .BAR_BITS (BAR_BITS),
    .BAR_MAX  (BAR_MAX)
  ) u_chan_r (
    .clk            (clk),
    .reset_n        (reset_n),
    .sample_i       (sample_q[15:0]),
    .sample_valid_i (proc),
    .commit_i       (commit),
    .frame_tick_i   (frame_tick),
    .bar_o          (level_r)
  );

endmodule

// File: tb/tb_audio_level_meter.sv
// Bench for audio_level_meter: two instances (DECAY=64 and DECAY=20000, both
// WINDOW=4) share one FIFO model; expected bar heights are queued at each
// frame_tick and compared by a separate monitor.
module tb_audio_level_meter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] fifo_q = '0;
  logic        fifo_rdempty;
  logic        frame_tick = 1'b0;
  logic        fifo_rdreq, window_done;
  logic [8:0]  level_l, level_r;
  logic        fifo_rdreq2, window_done2;
  logic [8:0]  level_l2, level_r2;

  typedef struct {
    int l;
    int r;
    int l2;
  } exp_t;

  exp_t        exp_q[$];
  int          rq_cycles[$];
  logic [31:0] mem[0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          cyc = 0;
  int          wd_cnt = 0;
  int          wd2_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #10 clk = ~clk;

  audio_level_meter #(.WINDOW(4), .DECAY(64), .BAR_BITS(9), .BAR_MAX(479)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fifo_q       (fifo_q),
    .fifo_rdempty (fifo_rdempty),
    .fifo_rdreq   (fifo_rdreq),
    .frame_tick   (frame_tick),
    .level_l      (level_l),
    .level_r      (level_r),
    .window_done  (window_done)
  );

  audio_level_meter #(.WINDOW(4), .DECAY(20000), .BAR_BITS(9), .BAR_MAX(479)) dut_d (
    .clk          (clk),
    .reset_n      (reset_n),
    .fifo_q       (fifo_q),
    .fifo_rdempty (fifo_rdempty),
    .fifo_rdreq   (fifo_rdreq2),
    .frame_tick   (frame_tick),
    .level_l      (level_l2),
    .level_r      (level_r2),
    .window_done  (window_done2)
  );

  // Normal-mode FIFO: data valid the cycle after rdreq.
  assign fifo_rdempty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rdreq && (rd_ptr != wr_ptr)) begin
      fifo_q <= mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (fifo_rdreq) rq_cycles.push_back(cyc);
    if (window_done) wd_cnt++;
    if (window_done2) wd2_cnt++;
  end

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Monitor: every sampled frame_tick must update the bars to the queued values.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (frame_tick && reset_n) begin
        #1;
        if (exp_q.size() == 0) begin
          check("frame_without_expectation", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("level_l", int'(level_l), e.l);
          check("level_r", int'(level_r), e.r);
          check("level_l_decay20000", int'(level_l2), e.l2);
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  task automatic frame(input int l, input int r, input int l2);
    exp_t e;
    @(negedge clk);
    e.l  = l;
    e.r  = r;
    e.l2 = l2;
    exp_q.push_back(e);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Push one word from IDLE; optionally raise frame_tick during its PROC cycle.
  task automatic send(input logic [31:0] w, input bit tick, input int l, input int r, input int l2);
    exp_t e;
    push_word(w);
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (tick) begin
      e.l  = l;
      e.r  = r;
      e.l2 = l2;
      exp_q.push_back(e);
      frame_tick = 1'b1;
    end
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rdreq", int'(fifo_rdreq), 0);
    check("reset_level_l", int'(level_l), 0);
    check("reset_level_r", int'(level_r), 0);
    check("reset_window_done", int'(window_done), 0);
    reset_n = 1'b1;

    repeat (100) @(negedge clk);
    check("rdreq_while_empty", rq_cycles.size(), 0);

    rq_cycles.delete();
    push_word(32'h4000_C000);
    push_word(32'h4000_C000);
    push_word(32'h4000_C000);
    repeat (16) @(negedge clk);
    check("rdreq_pulse_count", rq_cycles.size(), 3);
    if (rq_cycles.size() == 3) begin
      check("rdreq_spacing_1", rq_cycles[1] - rq_cycles[0], 4);
      check("rdreq_spacing_2", rq_cycles[2] - rq_cycles[1], 4);
    end
    check("fifo_words_popped", rd_ptr, 3);

    // Fourth word commits the window while frame_tick is high: bars keep old value.
    send(32'h4000_C000, 1'b1, 0, 0, 0);
    frame(256, 256, 256);
    frame(256, 256, 256);

    // Window of zeros: 16384-64 = 16320 -> 255; DECAY=20000 empties to 0.
    repeat (4) send(32'h0000_0000, 1'b0, 0, 0, 0);
    frame(255, 255, 0);

    // Full-scale window: 32767 -> 511 clamped to 479.
    repeat (4) send(32'h8000_7FFF, 1'b0, 0, 0, 0);
    frame(479, 479, 479);

    // Reset while in WAIT with a word already popped.
    push_word(32'h7FFF_7FFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_rdreq", int'(fifo_rdreq), 0);
    check("midreset_level_l", int'(level_l), 0);
    check("midreset_level_r", int'(level_r), 0);
    check("midreset_window_done", int'(window_done), 0);
    check("midreset_level_l_decay20000", int'(level_l2), 0);
    check("midreset_word_was_popped", rd_ptr, wr_ptr);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    frame(0, 0, 0);

    // Asymmetric window: L peak 28672 -> 448, R peak 20480 -> 320.
    send(32'h1000_F000, 1'b0, 0, 0, 0);
    send(32'h7000_0400, 1'b0, 0, 0, 0);
    send(32'hFFFF_B000, 1'b0, 0, 0, 0);
    send(32'h0001_0001, 1'b0, 0, 0, 0);
    frame(448, 320, 448);

    repeat (5) @(negedge clk);
    check("window_done_pulses", wd_cnt, 4);
    check("window_done_pulses_decay20000", wd2_cnt, 4);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
